// File: rtl/carry_save_resolver.sv
// Resolves a redundant (sum, carry) pair to binary, CHUNK bits per clock.
// Valid/ready on both sides; the result is held until the sink takes it.
module carry_save_resolver #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_sum,
    input  logic [N-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+1:0] out_result,
    output logic         busy
);

    localparam int W   = N + 2;
    localparam int NCH = (W + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_nxt;
    logic [KW-1:0]   k_q;
    logic            c_q;
    logic [CHUNK:0]  csum;
    logic [W-1:0]    res_q;
    logic            accept;
    logic            last_chunk;

    assign accept     = in_valid && (state == IDLE);
    assign last_chunk = (k_q == KW'(NCH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one pass through BUSY per chunk, then wait for the sink
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // One chunk of the carry-propagate add, with the carry from the chunk below
    always_comb begin
        csum = {1'b0, a_q[k_q*CHUNK +: CHUNK]}
             + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_q};
        acc_nxt = acc_q;
        acc_nxt[k_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    // Operand capture, chunk iteration, and publishing the finished result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            k_q   <= '0;
            c_q   <= 1'b0;
            res_q <= '0;
        end else if (accept) begin
            a_q   <= {{(PW-N){1'b0}}, in_sum};
            b_q   <= {{(PW-N-1){1'b0}}, in_carry, 1'b0};
            acc_q <= '0;
            k_q   <= '0;
            c_q   <= 1'b0;
        end else if (state == BUSY) begin
            acc_q <= acc_nxt;
            c_q   <= csum[CHUNK];
            if (last_chunk) begin
                res_q <= acc_nxt[W-1:0];
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    assign out_result = res_q;

    // The top chunk can never carry out: 3*(2^N-1) fits in N+2 bits
    always @(posedge clk) begin
        if (rst_n && state == BUSY && last_chunk) begin
            assert (!csum[CHUNK]);
        end
    end

endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed and randomized checks of carry_save_resolver
// against value = sum + 2*carry computed with plain arithmetic.
module tb_carry_save_resolver;

    localparam int N     = 8;
    localparam int CHUNK = 4;
    localparam int W     = N + 2;
    localparam int NCH   = (W + CHUNK - 1) / CHUNK;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_sum = '0;
    logic [N-1:0] in_carry = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    carry_save_resolver #(.N(N), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [N-1:0] s, input logic [N-1:0] c);
        int unsigned v;
        v = int'(s) + 2 * int'(c);
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one operand pair, measure latency, hold the result for 'hold'
    // cycles, then take it.
    task automatic do_op(input string tag, input logic [N-1:0] s,
                         input logic [N-1:0] c, input int hold);
        logic [31:0] exp;
        int t;
        int lat;
        exp = model(s, c);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sum    = s;
        in_carry  = c;
        out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_accept_timeout"}, 32'(t < 40), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sum   = N'($urandom);
        in_carry = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NCH));
        check({tag, "_result"}, 32'(out_result), exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_after_hs"}, {30'd0, out_valid, in_ready}, 32'b01);
        check({tag, "_held_result"}, 32'(out_result), exp);
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_v;
    int          cyc;
    int          last_acc;
    int          nres;
    bit          acc;
    bit          hs;
    int          t;

    initial begin
        // Reset state
        #12;
        check("rst_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        check("rst_result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_outputs", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Directed vectors
        do_op("ff_ff", 8'hFF, 8'hFF, 0);
        check("ff_ff_abs", 32'(out_result), 32'h2FD);
        do_op("00_80", 8'h00, 8'h80, 1);
        check("00_80_abs", 32'(out_result), 32'h100);
        do_op("55_aa", 8'h55, 8'hAA, 0);
        check("55_aa_abs", 32'(out_result), 32'h1A9);
        do_op("00_00", 8'h00, 8'h00, 0);
        check("00_00_abs", 32'(out_result), 32'h000);

        // Stall in DONE while a second operand is offered
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = 8'h12;
        in_carry = 8'h34;
        @(posedge clk);
        #1;
        in_sum   = 8'hEE;
        in_carry = 8'hDD;
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        exp_v = model(8'h12, 8'h34);
        check("stall_latency", 32'(t), 32'(NCH));
        for (int i = 0; i < 6; i++) begin
            check("stall_flags", {29'd0, out_valid, busy, in_ready}, 32'b110);
            check("stall_result", 32'(out_result), exp_v);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_released", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second_taken", 32'(busy), 32'd1);
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("second_result", 32'(out_result), model(8'hEE, 8'hDD));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second BUSY cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = 8'hA5;
        in_carry = 8'h5A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("midrst_result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", {30'd0, out_valid, in_ready}, 32'b01);
        end
        do_op("post_rst", 8'hA5, 8'h5A, 0);

        // Streaming: in_valid and out_ready held high
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_sum    = N'($urandom);
        in_carry  = N'($urandom);
        cyc = 0;
        last_acc = -1;
        nres = 0;
        while (nres < 100 && cyc < 2000) begin
            acc = in_ready;
            hs  = out_valid;
            if (acc) begin
                q.push_back(model(in_sum, in_carry));
                if (last_acc >= 0) begin
                    check("stream_interval", 32'(cyc - last_acc), 32'(NCH + 2));
                end
                last_acc = cyc;
            end
            if (hs) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD;
                check("stream_result", 32'(out_result), exp_v);
                nres++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                in_sum   = N'($urandom);
                in_carry = N'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 32'(nres), 32'd100);
        check("stream_drained", 32'(q.size()), 32'd0);

        // Random single operations with random DONE hold
        for (int i = 0; i < 1000; i++) begin
            do_op("rand", N'($urandom), N'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
